// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer driving the CPU datapath strobes.
// Optional SINGLE_STEP_EN adds a step input that gates each instruction at T0.
module control_sequencer #(
  parameter int unsigned OPW           = 5,
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clock,
  input  logic        clear,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        run,
  output logic        illegal,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        memRead,
  output logic        ramEnable,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        ADD,
  output logic        Cout,
  output logic        HIout,
  output logic        LOout,
  output logic        CONin,
  output logic        InPort_Out,
  output logic        OutPort_In
);

  localparam int unsigned HW = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_BRX  = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [HW-1:0]   r_hold_cnt;
  logic            w_hold_done;
  logic [OPW-1:0]  w_opcode;
  logic            w_alu_r;
  logic            w_alu_i;
  logic            w_mem;
  logic            w_unused_ir;

  assign w_opcode    = IR[31 -: OPW];
  assign w_unused_ir = ^IR[31-OPW:0];
  assign w_alu_r     = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                       (w_opcode == OP_AND) || (w_opcode == OP_OR);
  assign w_alu_i     = (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                       (w_opcode == OP_ORI);
  assign w_mem       = (w_opcode == OP_LD) || (w_opcode == OP_LDI) ||
                       (w_opcode == OP_ST);
  assign w_hold_done = (32'(r_hold_cnt) + 32'd1) >= RESET_PC_HOLD;

  // State register; clear drops straight back to RESET
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RESET;
    else        r_state <= w_next_state;
  end

  // Counts idle RESET cycles after clear is released
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                               r_hold_cnt <= '0;
    else if (r_state == S_RESET && !w_hold_done) r_hold_cnt <= r_hold_cnt + HW'(1);
    else                                      r_hold_cnt <= '0;
  end

`ifdef SINGLE_STEP_EN
  logic r_step_go;

  // Armed for one T0 cycle after step is seen while waiting in T0
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)               r_step_go <= 1'b0;
    else if (r_state == S_T0) r_step_go <= r_step_go ? 1'b0 : step;
    else                      r_step_go <= 1'b0;
  end
`endif

  always_comb begin
    w_next_state = r_state;
    run        = 1'b0;
    illegal    = 1'b0;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    memRead    = 1'b0;
    ramEnable  = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    ADD        = 1'b0;
    Cout       = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    CONin      = 1'b0;
    InPort_Out = 1'b0;
    OutPort_In = 1'b0;

    case (r_state)
      S_RESET: if (w_hold_done) w_next_state = S_T0;
      S_T0: begin
        run = 1'b1;
`ifdef SINGLE_STEP_EN
        if (r_step_go) begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
          w_next_state = S_T1;
        end
`else
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        w_next_state = S_T1;
`endif
      end
      S_T1: begin
        run = 1'b1; memRead = 1'b1; MDRin = 1'b1;
        w_next_state = S_T2;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        if (w_opcode == OP_NOP)       w_next_state = S_T0;
        else if (w_opcode == OP_HALT) w_next_state = S_HALTED;
        else                          w_next_state = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        w_next_state = S_T0;
        if (w_alu_r || w_alu_i) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; w_next_state = S_T4;
        end else if (w_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; w_next_state = S_T4;
        end else begin
          case (w_opcode)
            OP_BRX:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; w_next_state = S_T4; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: illegal = 1'b1;
          endcase
        end
      end
      S_T4: begin
        run = 1'b1;
        w_next_state = S_T5;
        if (w_alu_r)                begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
        else if (w_alu_i)           begin Cout = 1'b1; Zin = 1'b1; end
        else if (w_mem)             begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
        else if (w_opcode == OP_BRX) begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        run = 1'b1;
        w_next_state = S_T0;
        if (w_alu_r || w_alu_i || w_opcode == OP_LDI) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_opcode == OP_LD || w_opcode == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1; w_next_state = S_T6;
        end else if (w_opcode == OP_BRX) begin
          Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; w_next_state = S_T6;
        end
      end
      S_T6: begin
        run = 1'b1;
        w_next_state = S_T0;
        if (w_opcode == OP_LD) begin
          memRead = 1'b1; MDRin = 1'b1; w_next_state = S_T7;
        end else if (w_opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; w_next_state = S_T7;
        end else if (w_opcode == OP_BRX && CON) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        w_next_state = S_T0;
        if (w_opcode == OP_LD)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (w_opcode == OP_ST) ramEnable = 1'b1;
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle strobe vectors queued per instruction.
module tb_control_sequencer;

  localparam int unsigned HOLD = 1;

  localparam logic [27:0] M_RUN   = 28'd1 << 27;
  localparam logic [27:0] M_ILL   = 28'd1 << 26;
  localparam logic [27:0] M_PCOUT = 28'd1 << 25;
  localparam logic [27:0] M_PCIN  = 28'd1 << 24;
  localparam logic [27:0] M_INCPC = 28'd1 << 23;
  localparam logic [27:0] M_MARIN = 28'd1 << 22;
  localparam logic [27:0] M_MDRIN = 28'd1 << 21;
  localparam logic [27:0] M_MDROUT= 28'd1 << 20;
  localparam logic [27:0] M_MEMRD = 28'd1 << 19;
  localparam logic [27:0] M_RAMEN = 28'd1 << 18;
  localparam logic [27:0] M_IRIN  = 28'd1 << 17;
  localparam logic [27:0] M_GRA   = 28'd1 << 16;
  localparam logic [27:0] M_GRB   = 28'd1 << 15;
  localparam logic [27:0] M_GRC   = 28'd1 << 14;
  localparam logic [27:0] M_RIN   = 28'd1 << 13;
  localparam logic [27:0] M_ROUT  = 28'd1 << 12;
  localparam logic [27:0] M_BAOUT = 28'd1 << 11;
  localparam logic [27:0] M_YIN   = 28'd1 << 10;
  localparam logic [27:0] M_ZIN   = 28'd1 << 9;
  localparam logic [27:0] M_ZLO   = 28'd1 << 8;
  localparam logic [27:0] M_ADD   = 28'd1 << 6;
  localparam logic [27:0] M_COUT  = 28'd1 << 5;
  localparam logic [27:0] M_HIOUT = 28'd1 << 4;
  localparam logic [27:0] M_LOOUT = 28'd1 << 3;
  localparam logic [27:0] M_CONIN = 28'd1 << 2;
  localparam logic [27:0] M_INP   = 28'd1 << 1;
  localparam logic [27:0] M_OUTP  = 28'd1 << 0;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON;
  logic        step;
  logic run, illegal, PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead, ramEnable;
  logic IRin, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zlowout, Zhighout, ADD, Cout;
  logic HIout, LOout, CONin, InPort_Out, OutPort_In;
  logic [27:0] obs;

  logic [27:0] sb[$];
  string       tq[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  control_sequencer #(.OPW(5), .RESET_PC_HOLD(HOLD)) dut (
    .clock(clock), .clear(clear),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .IR(IR), .CON(CON), .run(run), .illegal(illegal),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .memRead(memRead), .ramEnable(ramEnable), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .ADD(ADD),
    .Cout(Cout), .HIout(HIout), .LOout(LOout), .CONin(CONin),
    .InPort_Out(InPort_Out), .OutPort_In(OutPort_In)
  );

  assign obs = {run, illegal, PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead,
                ramEnable, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zlowout,
                Zhighout, ADD, Cout, HIout, LOout, CONin, InPort_Out, OutPort_In};

  task automatic check(input string tag, input logic [27:0] o, input logic [27:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic pe(input string t, input logic [27:0] v);
    sb.push_back(M_RUN | v);
    tq.push_back(t);
  endtask

  // Expected per-cycle strobes for one instruction, fetch included
  task automatic push_instr(input string nm, input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    pe({nm, ".T0"}, M_PCOUT | M_MARIN | M_INCPC);
    pe({nm, ".T1"}, M_MEMRD | M_MDRIN);
    pe({nm, ".T2"}, M_MDROUT | M_IRIN);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        pe({nm, ".T3"}, M_GRB | M_ROUT | M_YIN);
        pe({nm, ".T4"}, M_GRC | M_ROUT | M_ZIN);
        pe({nm, ".T5"}, M_ZLO | M_GRA | M_RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        pe({nm, ".T3"}, M_GRB | M_ROUT | M_YIN);
        pe({nm, ".T4"}, M_COUT | M_ZIN);
        pe({nm, ".T5"}, M_ZLO | M_GRA | M_RIN);
      end
      5'b00000, 5'b00001, 5'b00010: begin
        pe({nm, ".T3"}, M_GRB | M_BAOUT | M_YIN);
        pe({nm, ".T4"}, M_COUT | M_ADD | M_ZIN);
        if (op == 5'b00001) pe({nm, ".T5"}, M_ZLO | M_GRA | M_RIN);
        else                pe({nm, ".T5"}, M_ZLO | M_MARIN);
        if (op == 5'b00000) begin
          pe({nm, ".T6"}, M_MEMRD | M_MDRIN);
          pe({nm, ".T7"}, M_MDROUT | M_GRA | M_RIN);
        end else if (op == 5'b00010) begin
          pe({nm, ".T6"}, M_GRA | M_ROUT | M_MDRIN);
          pe({nm, ".T7"}, M_RAMEN);
        end
      end
      5'b10011: begin
        pe({nm, ".T3"}, M_GRA | M_ROUT | M_CONIN);
        pe({nm, ".T4"}, M_PCOUT | M_YIN);
        pe({nm, ".T5"}, M_COUT | M_ADD | M_ZIN);
        pe({nm, ".T6"}, con ? (M_ZLO | M_PCIN) : 28'd0);
      end
      5'b10100: pe({nm, ".T3"}, M_GRA | M_ROUT | M_PCIN);
      5'b10110: pe({nm, ".T3"}, M_INP | M_GRA | M_RIN);
      5'b10111: pe({nm, ".T3"}, M_GRA | M_ROUT | M_OUTP);
      5'b11000: pe({nm, ".T3"}, M_HIOUT | M_GRA | M_RIN);
      5'b11001: pe({nm, ".T3"}, M_LOOUT | M_GRA | M_RIN);
      5'b11010: ;
      5'b11011: begin
        for (int i = 0; i < 22; i++) begin
          sb.push_back(28'd0);
          tq.push_back({nm, ".halted"});
        end
      end
      default: pe({nm, ".T3"}, M_ILL);
    endcase
  endtask

  // Compare one queued vector per clock until the instruction is exhausted
  task automatic drain();
    logic [27:0] e;
    string       t;
    while (sb.size() > 0) begin
      @(negedge clock);
      e = sb.pop_front();
      t = tq.pop_front();
      check(t, obs, e);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exec(input string nm, input logic [31:0] ir, input logic con);
    IR  = ir;
    CON = con;
    push_instr(nm, ir, con);
    drain();
  endtask

  // Asserts clear now, releases it on a falling edge, ends just after the edge into T0
  task automatic do_reset(input string nm);
    #1 clear = 1'b0;
    #1 check({nm, ".async"}, obs, 28'd0);
    @(negedge clock);
    clear = 1'b1;
    #1 check({nm, ".held"}, obs, 28'd0);
    for (int i = 1; i < int'(HOLD); i++) begin
      @(posedge clock);
      #1 check({nm, ".hold_cyc"}, obs, 28'd0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [27:0] e;
    string       t;
    clear = 1'b0;
    IR    = 32'h0;
    CON   = 1'b0;
    step  = 1'b1;
    do_reset("por");

    // Reset in T6 of ld: compare T0..T6 then pull clear
    IR = 32'h00800005;
    push_instr("ld_abort", IR, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      e = sb.pop_front();
      t = tq.pop_front();
      check(t, obs, e);
      if (i < 6) begin
        @(posedge clock);
        #1;
      end
    end
    sb.delete();
    tq.delete();
    do_reset("midld");

    exec("andi", 32'h69A00053, 1'b0);
    exec("ld",   32'h00800005, 1'b0);
    exec("st",   32'h10800005, 1'b0);
    exec("brx0", 32'h98000010, 1'b0);
    exec("brx1", 32'h98000010, 1'b1);
    exec("in",   32'hB0800000, 1'b0);
    exec("mflo", 32'hC8800000, 1'b0);
    exec("nop",  32'hD0000000, 1'b0);
    exec("add",  32'h18800000, 1'b0);
    exec("ori",  32'h70800001, 1'b0);
    exec("ldi",  32'h08800007, 1'b0);
    exec("jr",   32'hA0800000, 1'b0);
    exec("out",  32'hB8800000, 1'b0);
    exec("mfhi", 32'hC0800000, 1'b0);
    exec("illg", 32'hF8000000, 1'b0);
    exec("halt", 32'hD8000000, 1'b0);
    do_reset("unhalt");
    exec("sub",  32'h20800000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
